// File: rtl/mic_pkg.sv
// Shared constants and enumerations for the MIC register bank and its request channels.
package mic_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned NREGS  = 9;

   // Register index as used by the C-bus write mask and the B-bus select
   typedef enum logic [3:0] {
      R_H   = 4'd0,
      R_OPC = 4'd1,
      R_TOS = 4'd2,
      R_CPP = 4'd3,
      R_LV  = 4'd4,
      R_SP  = 4'd5,
      R_PC  = 4'd6,
      R_MDR = 4'd7,
      R_MAR = 4'd8
   } reg_idx_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_PEND = 2'd1,
      WR_PEND = 2'd2
   } mem_state_e;

   typedef enum logic {
      F_IDLE = 1'b0,
      F_PEND = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/mic_req_chan.sv
// One request/ack channel: captures an address on an accepted strobe, holds a
// level request until ack, and flags strobes that arrive while still pending.
module mic_req_chan
   import mic_pkg::*;
#(
   parameter int unsigned ADDR_W = mic_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              strobe_i,
   input  logic              wr_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              ack_i,
   output logic [1:0]        state_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              accept_c,
   output logic              done_c,
   output logic              viol_c
);

   mem_state_e        state_q;
   logic [ADDR_W-1:0] addr_q;

   // Channel FSM: IDLE accepts a strobe, any pending state waits for ack
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (strobe_i) begin
                  state_q <= wr_i ? WR_PEND : RD_PEND;
                  addr_q  <= addr_i;
               end
            end
            default: begin
               if (ack_i) begin
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end

   // Same-edge status seen by the owner of this channel
   always_comb begin
      accept_c = strobe_i & (state_q == IDLE);
      done_c   = ack_i    & (state_q != IDLE);
      viol_c   = strobe_i & (state_q != IDLE);
   end

   assign state_o = state_q;
   assign addr_o  = addr_q;

endmodule

// File: rtl/mic_reg_bank_cbus.sv
// MIC datapath register bank: C-bus writes, B-bus source mux, and the memory
// and opcode-fetch handshakes that load MDR and MBR.
module mic_reg_bank_cbus
   import mic_pkg::*;
#(
   parameter int unsigned DATA_W = mic_pkg::DATA_W,
   parameter int unsigned ADDR_W = mic_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] c_bus,
   input  logic [8:0]        c_wr,
   input  logic [2:0]        b_sel,
   output logic [DATA_W-1:0] b_bus,
   output logic [DATA_W-1:0] h_out,
   output logic [7:0]        mbr_out,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic              mem_fetch,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd_req,
   output logic              mem_wr_req,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_req,
   input  logic              fetch_ack,
   input  logic [7:0]        fetch_data,
   output logic              busy,
   output logic              err
);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [7:0]        mbr_q, mbr_d;
   logic              err_q, err_d;

   logic [1:0]   m_state;
   logic         m_accept, m_done, m_viol;
   logic [1:0]   f_state;
   logic         f_accept, f_done, f_viol;
   logic         rd_done;
   fetch_state_e f_st;

   assign rd_done = m_done & (mem_state_e'(m_state) == RD_PEND);

   // Memory read/write channel; the request type is write whenever mem_wr is set
   mic_req_chan #(.ADDR_W(ADDR_W)) u_mem_chan (
      .clk      (clk),
      .reset    (reset),
      .strobe_i (mem_rd | mem_wr),
      .wr_i     (mem_wr),
      .addr_i   (ADDR_W'(regs_d[R_MAR])),
      .ack_i    (mem_ack),
      .state_o  (m_state),
      .addr_o   (mem_addr),
      .accept_c (m_accept),
      .done_c   (m_done),
      .viol_c   (m_viol)
   );

   // Opcode fetch channel, always a read
   mic_req_chan #(.ADDR_W(ADDR_W)) u_fetch_chan (
      .clk      (clk),
      .reset    (reset),
      .strobe_i (mem_fetch),
      .wr_i     (1'b0),
      .addr_i   (ADDR_W'(regs_d[R_PC])),
      .ack_i    (fetch_ack),
      .state_o  (f_state),
      .addr_o   (fetch_addr),
      .accept_c (f_accept),
      .done_c   (f_done),
      .viol_c   (f_viol)
   );

   // Next register values: C bus first, read data into MDR only when C bus leaves it alone
   always_comb begin
      for (int i = 0; i < int'(NREGS); i++) begin
         regs_d[i] = c_wr[i] ? c_bus : regs_q[i];
      end
      if (rd_done && !c_wr[R_MDR]) begin
         regs_d[R_MDR] = mem_rdata;
      end
      wdata_d = m_accept ? regs_d[R_MDR] : wdata_q;
      mbr_d   = f_done ? fetch_data : mbr_q;
      err_d   = err_q | m_viol | f_viol
              | (m_accept & mem_rd & mem_wr)
              | (rd_done & c_wr[R_MDR]);
   end

   // Register array, MBR, captured write data and sticky error
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= '0;
         end
         wdata_q <= '0;
         mbr_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= regs_d[i];
         end
         wdata_q <= wdata_d;
         mbr_q   <= mbr_d;
         err_q   <= err_d;
      end
   end

   // Output decode, all from current register state
   always_comb begin
      f_st       = (f_state != 2'(IDLE)) ? F_PEND : F_IDLE;
      b_bus      = regs_q[4'(b_sel)];
      h_out      = regs_q[R_H];
      mbr_out    = mbr_q;
      mem_wdata  = wdata_q;
      mem_rd_req = (mem_state_e'(m_state) == RD_PEND);
      mem_wr_req = (mem_state_e'(m_state) == WR_PEND);
      fetch_req  = (f_st == F_PEND);
      busy       = (mem_state_e'(m_state) != IDLE) | (f_st != F_IDLE);
      err        = err_q;
   end

endmodule

// File: tb/tb_mic_reg_bank_cbus.sv
// Self-checking bench for mic_reg_bank_cbus: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_mic_reg_bank_cbus;

   logic        clk;
   logic        reset;
   logic [31:0] c_bus;
   logic [8:0]  c_wr;
   logic [2:0]  b_sel;
   logic [31:0] b_bus;
   logic [31:0] h_out;
   logic [7:0]  mbr_out;
   logic        mem_rd, mem_wr, mem_fetch;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_rd_req, mem_wr_req;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] fetch_addr;
   logic        fetch_req, fetch_ack;
   logic [7:0]  fetch_data;
   logic        busy, err;

   mic_reg_bank_cbus dut (
      .clk        (clk),
      .reset      (reset),
      .c_bus      (c_bus),
      .c_wr       (c_wr),
      .b_sel      (b_sel),
      .b_bus      (b_bus),
      .h_out      (h_out),
      .mbr_out    (mbr_out),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .mem_fetch  (mem_fetch),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rd_req (mem_rd_req),
      .mem_wr_req (mem_wr_req),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .fetch_addr (fetch_addr),
      .fetch_req  (fetch_req),
      .fetch_ack  (fetch_ack),
      .fetch_data (fetch_data),
      .busy       (busy),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   // Model: register file, pending kind per channel (0 none, 1 read, 2 write)
   logic [31:0] m_reg [9];
   int          m_mem;
   bit          m_f;
   logic [31:0] m_addr, m_wdata, m_faddr;
   logic [7:0]  m_mbr;
   bit          m_err;

   function automatic void cmp(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end else begin
         n_pass++;
      end
   endfunction

   // Apply one clock edge's worth of the rules to the model
   task automatic model_update();
      logic [31:0] nr [9];
      int nm;
      bit nf;
      if (reset) begin
         for (int i = 0; i < 9; i++) m_reg[i] = '0;
         m_mem = 0; m_f = 1'b0; m_addr = '0; m_wdata = '0; m_faddr = '0;
         m_mbr = '0; m_err = 1'b0;
      end else begin
         for (int i = 0; i < 9; i++) nr[i] = c_wr[i] ? c_bus : m_reg[i];
         nm = m_mem;
         nf = m_f;
         if (m_mem != 0 && mem_ack) begin
            if (m_mem == 1) begin
               if (c_wr[7]) m_err = 1'b1;
               else nr[7] = mem_rdata;
            end
            nm = 0;
         end
         if (mem_rd || mem_wr) begin
            if (m_mem != 0) begin
               m_err = 1'b1;
            end else begin
               m_addr  = nr[8];
               m_wdata = nr[7];
               nm      = mem_wr ? 2 : 1;
               if (mem_rd && mem_wr) m_err = 1'b1;
            end
         end
         if (m_f && fetch_ack) begin
            m_mbr = fetch_data;
            nf    = 1'b0;
         end
         if (mem_fetch) begin
            if (m_f) begin
               m_err = 1'b1;
            end else begin
               m_faddr = nr[6];
               nf      = 1'b1;
            end
         end
         for (int i = 0; i < 9; i++) m_reg[i] = nr[i];
         m_mem = nm;
         m_f   = nf;
      end
   endtask

   task automatic clear_in();
      c_wr = '0; mem_rd = 1'b0; mem_wr = 1'b0; mem_fetch = 1'b0;
      mem_ack = 1'b0; fetch_ack = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
      clear_in();
   endtask

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("b_bus",      b_bus,              m_reg[int'(b_sel)]);
         cmp("h_out",      h_out,              m_reg[0]);
         cmp("mbr_out",    32'(mbr_out),       32'(m_mbr));
         cmp("mem_addr",   mem_addr,           m_addr);
         cmp("mem_wdata",  mem_wdata,          m_wdata);
         cmp("mem_rd_req", 32'(mem_rd_req),    32'(m_mem == 1));
         cmp("mem_wr_req", 32'(mem_wr_req),    32'(m_mem == 2));
         cmp("fetch_addr", fetch_addr,         m_faddr);
         cmp("fetch_req",  32'(fetch_req),     32'(m_f));
         cmp("busy",       32'(busy),          32'((m_mem != 0) || m_f));
         cmp("err",        32'(err),           32'(m_err));
      end
   end

   initial begin
      reset = 1'b1; c_bus = '0; b_sel = '0; mem_rdata = '0; fetch_data = '0;
      clear_in();

      // Reset state
      tick();
      chk_en = 1'b1;
      reset  = 1'b0;
      #1;
      cmp("rst_h",    h_out, 32'h0);
      cmp("rst_busy", 32'(busy), 32'h0);
      cmp("rst_err",  32'(err), 32'h0);
      cmp("rst_mbr",  32'(mbr_out), 32'h0);

      // H write, then B bus sweep
      c_wr = 9'h001; c_bus = 32'd5;
      tick();
      #1;
      cmp("h_write", h_out, 32'd5);
      for (int s = 0; s < 8; s++) begin
         b_sel = 3'(s);
         #1;
         cmp("b_sweep", b_bus, (s == 0) ? 32'd5 : 32'd0);
      end

      // Mask 0x060 loads SP and PC together; LV stays 0
      c_wr = 9'h060; c_bus = 32'hAA;
      tick();
      b_sel = 3'd4; #1; cmp("lv_untouched", b_bus, 32'h0);
      b_sel = 3'd5; #1; cmp("sp_aa", b_bus, 32'hAA);
      b_sel = 3'd6; #1; cmp("pc_aa", b_bus, 32'hAA);

      // Read using same-cycle MAR write, with a concurrent fetch
      c_wr = 9'h100; c_bus = 32'h10; mem_rd = 1'b1;
      tick();
      #1;
      cmp("rd_addr", mem_addr, 32'h10);
      cmp("rd_req",  32'(mem_rd_req), 32'h1);
      cmp("rd_busy", 32'(busy), 32'h1);
      c_wr = 9'h040; c_bus = 32'd4; mem_fetch = 1'b1;
      tick();
      #1;
      cmp("f_addr",     fetch_addr, 32'd4);
      cmp("f_req",      32'(fetch_req), 32'h1);
      cmp("rd_req_hold", 32'(mem_rd_req), 32'h1);
      fetch_ack = 1'b1; fetch_data = 8'h9C;
      tick();
      #1;
      cmp("mbr_9c",     32'(mbr_out), 32'h9C);
      cmp("f_req_drop", 32'(fetch_req), 32'h0);
      cmp("rd_req_hold2", 32'(mem_rd_req), 32'h1);
      mem_ack = 1'b1; mem_rdata = 32'hBEEF;
      tick();
      b_sel = 3'd7;
      #1;
      cmp("mdr_beef",    b_bus, 32'hBEEF);
      cmp("rd_req_drop", 32'(mem_rd_req), 32'h0);
      cmp("idle_busy",   32'(busy), 32'h0);
      cmp("no_err",      32'(err), 32'h0);

      // Second read while pending
      mem_rd = 1'b1;
      tick();
      mem_rd = 1'b1;
      tick();
      #1;
      cmp("dup_err", 32'(err), 32'h1);
      cmp("dup_req", 32'(mem_rd_req), 32'h1);
      mem_ack = 1'b1;
      tick();
      #1;
      cmp("dup_done", 32'(mem_rd_req), 32'h0);

      // Read and write together
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      cmp("err_cleared", 32'(err), 32'h0);
      mem_rd = 1'b1; mem_wr = 1'b1;
      tick();
      #1;
      cmp("both_wr", 32'(mem_wr_req), 32'h1);
      cmp("both_rd", 32'(mem_rd_req), 32'h0);
      cmp("both_err", 32'(err), 32'h1);
      mem_ack = 1'b1;
      tick();

      // Read ack collides with a C write to MDR
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mem_rd = 1'b1;
      tick();
      mem_ack = 1'b1; mem_rdata = 32'h1234; c_wr = 9'h080; c_bus = 32'h77;
      tick();
      b_sel = 3'd7;
      #1;
      cmp("cbus_wins", b_bus, 32'h77);
      cmp("cbus_err",  32'(err), 32'h1);

      // Reset during a write, then a late ack
      reset = 1'b1;
      tick();
      reset = 1'b0;
      c_wr = 9'h080; c_bus = 32'h55; mem_wr = 1'b1;
      tick();
      #1;
      cmp("wr_req",   32'(mem_wr_req), 32'h1);
      cmp("wr_wdata", mem_wdata, 32'h55);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      cmp("wr_req_rst", 32'(mem_wr_req), 32'h0);
      c_wr = 9'h080; c_bus = 32'h66;
      tick();
      mem_ack = 1'b1; mem_rdata = 32'hDEAD;
      tick();
      b_sel = 3'd7;
      #1;
      cmp("late_ack_mdr",  b_bus, 32'h66);
      cmp("late_ack_err",  32'(err), 32'h0);
      cmp("late_ack_busy", 32'(busy), 32'h0);

      // Randomized traffic, checked every cycle by the compare process
      for (int n = 0; n < 3000; n++) begin
         reset      = ($urandom_range(0, 149) == 0);
         c_wr       = ($urandom_range(0, 2) == 0) ? 9'($urandom) : 9'h0;
         c_bus      = $urandom;
         b_sel      = 3'($urandom);
         mem_rd     = ($urandom_range(0, 7) == 0);
         mem_wr     = ($urandom_range(0, 7) == 0);
         mem_fetch  = ($urandom_range(0, 5) == 0);
         mem_ack    = ($urandom_range(0, 2) == 0);
         mem_rdata  = $urandom;
         fetch_ack  = ($urandom_range(0, 2) == 0);
         fetch_data = 8'($urandom);
         tick();
      end
      reset = 1'b0;
      tick();
      @(negedge clk);
      #1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
